// File: rtl/fft_rx_pkg.sv
// Shared types and defaults for the FFT source-stream receiver.
package fft_rx_pkg;

   localparam int FFT_LEN_DEF = 512;
   localparam int DATA_W_DEF  = 16;
   localparam int EXP_W_DEF   = 6;

   // Bit positions inside the 3-bit frame error word.
   localparam int ERR_CORE    = 0;
   localparam int ERR_RESTART = 1;
   localparam int ERR_LONG    = 2;
   localparam int ERR_W       = 3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      HOLD    = 2'd2
   } rx_state_e;

endpackage

// File: rtl/fft_mag_sq.sv
// One-stage registered magnitude-squared unit: mag = re^2 + im^2, unsigned.
module fft_mag_sq #(
   parameter int DATA_W = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en_i,
   input  logic signed [DATA_W-1:0] re_i,
   input  logic signed [DATA_W-1:0] im_i,
   output logic [2*DATA_W:0]        mag_o
);

   logic signed [2*DATA_W-1:0] re_ext;
   logic signed [2*DATA_W-1:0] im_ext;
   logic        [2*DATA_W-1:0] re_sq;
   logic        [2*DATA_W-1:0] im_sq;
   logic        [2*DATA_W:0]   mag_d;
   logic        [2*DATA_W:0]   mag_q;

   // Squares of a signed value are never negative and fit in 2*DATA_W bits,
   // so the sum needs exactly one extra bit.
   assign re_ext = (2*DATA_W)'(re_i);
   assign im_ext = (2*DATA_W)'(im_i);
   assign re_sq  = re_ext * re_ext;
   assign im_sq  = im_ext * im_ext;
   assign mag_d  = {1'b0, re_sq} + {1'b0, im_sq};

   // Result register, loaded only when a valid sample is presented.
   always_ff @(posedge clk) begin
      if (rst) begin
         mag_q <= '0;
      end else if (en_i) begin
         mag_q <= mag_d;
      end
   end

   assign mag_o = mag_q;

endmodule

// File: rtl/fft_frame_rx.sv
// Receive side of the FFT Avalon-ST source stream: checks sop/eop framing
// against FFT_LEN, writes each bin to an external frame buffer and holds the
// core off until the consumer releases the buffer.
// Define FFT_RX_MAG_EN to write |X|^2 instead of {real, imag}; this adds one
// pipeline stage on the buffer write port.
module fft_frame_rx
   import fft_rx_pkg::*;
#(
   parameter  int FFT_LEN = FFT_LEN_DEF,
   parameter  int DATA_W  = DATA_W_DEF,
   parameter  int EXP_W   = EXP_W_DEF,
   localparam int ADDR_W  = $clog2(FFT_LEN),
`ifdef FFT_RX_MAG_EN
   localparam int WR_W    = 2*DATA_W+1
`else
   localparam int WR_W    = 2*DATA_W
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              source_valid,
   input  logic              source_sop,
   input  logic              source_eop,
   input  logic [DATA_W-1:0] source_real,
   input  logic [DATA_W-1:0] source_imag,
   input  logic [EXP_W-1:0]  source_exp,
   input  logic [1:0]        source_error,
   output logic              source_ready,
   output logic              buf_wr_en,
   output logic [ADDR_W-1:0] buf_wr_addr,
   output logic [WR_W-1:0]   buf_wr_data,
   output logic              frame_done,
   output logic [EXP_W-1:0]  frame_exp,
   output logic [ERR_W-1:0]  frame_err,
   output logic              frame_drop,
   input  logic              rd_release
);

   localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(FFT_LEN-1);

   rx_state_e           state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic [ERR_W-1:0]    err_q, err_d;
   logic [EXP_W-1:0]    exp_q, exp_d;
   logic                ready_q;

   logic                beat;
   logic                core_err;
   logic                wr_d;
   logic [ADDR_W-1:0]   addr_d;
   logic                last_d;
   logic                short_d;

   logic                wr_en_q;
   logic [ADDR_W-1:0]   wr_addr_q;
   logic [2*DATA_W-1:0] wr_data_q;
   logic                last_q;
   logic                short_q;

   logic                last_w;
   logic                short_w;

   logic                done_q;
   logic                drop_q;
   logic [ERR_W-1:0]    ferr_q;
   logic [EXP_W-1:0]    fexp_q;

   assign beat     = source_valid & ready_q;
   assign core_err = |source_error;

   // Framing FSM: next state, bin counter, error flags and write request.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one
      // unassigned; otherwise synthesis infers a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      exp_d   = exp_q;
      wr_d    = 1'b0;
      addr_d  = cnt_q;
      last_d  = 1'b0;
      short_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (beat && source_sop) begin
               wr_d            = 1'b1;
               addr_d          = '0;
               exp_d           = source_exp;
               err_d           = '0;
               err_d[ERR_CORE] = core_err;
               cnt_d           = ADDR_W'(1);
               state_d         = CAPTURE;
            end
         end

         CAPTURE: begin
            if (beat) begin
               wr_d            = 1'b1;
               err_d[ERR_CORE] = err_q[ERR_CORE] | core_err;
               if (source_sop) begin
                  // Restart: this beat becomes bin 0 of a fresh frame.
                  addr_d             = '0;
                  exp_d              = source_exp;
                  err_d              = '0;
                  err_d[ERR_RESTART] = 1'b1;
                  err_d[ERR_CORE]    = core_err;
                  cnt_d              = ADDR_W'(1);
               end else if (cnt_q == LAST_BIN) begin
                  err_d[ERR_LONG] = ~source_eop;
                  last_d          = 1'b1;
                  cnt_d           = '0;
                  state_d         = HOLD;
               end else if (source_eop) begin
                  short_d = 1'b1;
                  cnt_d   = '0;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + ADDR_W'(1);
               end
            end
         end

         HOLD: begin
            if (rd_release) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // Control state registers; source_ready is a registered decode of the next state.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         err_q   <= '0;
         exp_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         exp_q   <= exp_d;
         ready_q <= (state_d != HOLD);
      end
   end

   // First write stage: register the accepted beat and its framing markers.
   always_ff @(posedge clk) begin
      // NOTE: the datapath registers are reset too, because every output must
      // read 0 while rst is held, not just the strobes.
      if (rst) begin
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         last_q    <= 1'b0;
         short_q   <= 1'b0;
      end else begin
         wr_en_q <= wr_d;
         last_q  <= last_d;
         short_q <= short_d;
         if (wr_d) begin
            wr_addr_q <= addr_d;
            wr_data_q <= {source_real, source_imag};
         end
      end
   end

`ifdef FFT_RX_MAG_EN
   logic              wr_en_q2;
   logic [ADDR_W-1:0] wr_addr_q2;
   logic              last_q2;
   logic              short_q2;
   logic [WR_W-1:0]   mag;

   fft_mag_sq #(
      .DATA_W (DATA_W)
   ) u_mag (
      .clk   (clk),
      .rst   (rst),
      .en_i  (wr_en_q),
      .re_i  (wr_data_q[2*DATA_W-1:DATA_W]),
      .im_i  (wr_data_q[DATA_W-1:0]),
      .mag_o (mag)
   );

   // Second write stage: delay strobe, address and markers to match the squarer.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_en_q2   <= 1'b0;
         wr_addr_q2 <= '0;
         last_q2    <= 1'b0;
         short_q2   <= 1'b0;
      end else begin
         wr_en_q2   <= wr_en_q;
         wr_addr_q2 <= wr_addr_q;
         last_q2    <= last_q;
         short_q2   <= short_q;
      end
   end

   assign buf_wr_en   = wr_en_q2;
   assign buf_wr_addr = wr_addr_q2;
   assign buf_wr_data = mag;
   assign last_w      = last_q2;
   assign short_w     = short_q2;
`else
   assign buf_wr_en   = wr_en_q;
   assign buf_wr_addr = wr_addr_q;
   assign buf_wr_data = wr_data_q;
   assign last_w      = last_q;
   assign short_w     = short_q;
`endif

   // Frame status: pulses land one cycle after the final buffer write. err_q and
   // exp_q cannot change before this edge since the next frame's first beat is
   // at the earliest simultaneous with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         done_q <= 1'b0;
         drop_q <= 1'b0;
         ferr_q <= '0;
         fexp_q <= '0;
      end else begin
         done_q <= last_w;
         drop_q <= short_w;
         ferr_q <= last_w ? err_q : '0;
         if (last_w) begin
            fexp_q <= exp_q;
         end
      end
   end

   assign source_ready = ready_q;
   assign frame_done   = done_q;
   assign frame_drop   = drop_q;
   assign frame_err    = ferr_q;
   assign frame_exp    = fexp_q;

endmodule

// File: tb/tb_fft_frame_rx.sv
// Self-checking bench for fft_frame_rx: table of frame scenarios plus
// hand-written reset, hold-off and single-beat sequences.
module tb_fft_frame_rx;

   localparam int FFT_LEN = 512;
   localparam int DATA_W  = 16;
   localparam int EXP_W   = 6;
   localparam int ADDR_W  = 9;
`ifdef FFT_RX_MAG_EN
   localparam int WR_W = 2*DATA_W+1;
   localparam int LAT  = 2;
`else
   localparam int WR_W = 2*DATA_W;
   localparam int LAT  = 1;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              source_valid = 1'b0;
   logic              source_sop = 1'b0;
   logic              source_eop = 1'b0;
   logic [DATA_W-1:0] source_real = '0;
   logic [DATA_W-1:0] source_imag = '0;
   logic [EXP_W-1:0]  source_exp = '0;
   logic [1:0]        source_error = '0;
   logic              source_ready;
   logic              buf_wr_en;
   logic [ADDR_W-1:0] buf_wr_addr;
   logic [WR_W-1:0]   buf_wr_data;
   logic              frame_done;
   logic [EXP_W-1:0]  frame_exp;
   logic [2:0]        frame_err;
   logic              frame_drop;
   logic              rd_release = 1'b0;

   fft_frame_rx dut (
      .clk          (clk),
      .rst          (rst),
      .source_valid (source_valid),
      .source_sop   (source_sop),
      .source_eop   (source_eop),
      .source_real  (source_real),
      .source_imag  (source_imag),
      .source_exp   (source_exp),
      .source_error (source_error),
      .source_ready (source_ready),
      .buf_wr_en    (buf_wr_en),
      .buf_wr_addr  (buf_wr_addr),
      .buf_wr_data  (buf_wr_data),
      .frame_done   (frame_done),
      .frame_exp    (frame_exp),
      .frame_err    (frame_err),
      .frame_drop   (frame_drop),
      .rd_release   (rd_release)
   );

   initial forever #5 clk = ~clk;

   int cyc = 0;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   typedef struct {
      string      name;
      int         n_beats;
      int         eop_at;
      int         sop2_at;
      int         err_at;
      logic [5:0] exp;
      int         exp_writes;
      int         exp_last_addr;
      bit         exp_done;
      bit         exp_drop;
      logic [2:0] exp_err;
   } vec_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [WR_W-1:0]   data;
   } wr_t;

   int   n_checks = 0;
   int   n_pass   = 0;
   wr_t  exp_q[$];
   int   wr_cnt, bad_wr, done_cnt, drop_cnt;
   int   last_wr_cyc, done_cyc, drop_cyc;
   logic [ADDR_W-1:0] last_wr_addr;
   logic [2:0]        done_err;
   logic [EXP_W-1:0]  done_exp;
   logic [EXP_W-1:0]  prev_exp = '0;
   vec_t vecs[7];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_checks++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
   endtask

   function automatic logic [WR_W-1:0] exp_data(input int re, input int im);
`ifdef FFT_RX_MAG_EN
      return WR_W'(re*re + im*im);
`else
      logic [DATA_W-1:0] r;
      logic [DATA_W-1:0] i;
      r = DATA_W'(re);
      i = DATA_W'(im);
      return {r, i};
`endif
   endfunction

   // Write monitor / scoreboard, sampled on the falling edge.
   initial forever begin
      wr_t e;
      @(negedge clk);
      if (buf_wr_en) begin
         wr_cnt++;
         last_wr_addr = buf_wr_addr;
         last_wr_cyc  = cyc;
         if (exp_q.size() == 0) bad_wr++;
         else begin
            e = exp_q.pop_front();
            if (e.addr !== buf_wr_addr || e.data !== buf_wr_data) bad_wr++;
         end
      end
      if (frame_done) begin
         done_cnt++;
         done_cyc = cyc;
         done_err = frame_err;
         done_exp = frame_exp;
      end
      if (frame_drop) begin
         drop_cnt++;
         drop_cyc = cyc;
      end
   end

   task automatic clear_mon();
      exp_q.delete();
      wr_cnt = 0; bad_wr = 0; done_cnt = 0; drop_cnt = 0;
      last_wr_cyc = -1; done_cyc = -1; drop_cyc = -1;
   endtask

   task automatic idle_inputs();
      source_valid = 1'b0; source_sop = 1'b0; source_eop = 1'b0;
      source_real = '0; source_imag = '0; source_error = '0;
   endtask

   task automatic drive_beat(input int k, input int bin, input bit sop, input bit eop,
                             input logic [5:0] e, input bit err);
      source_valid = 1'b1;
      source_sop   = sop;
      source_eop   = eop;
      source_real  = DATA_W'(bin);
      source_imag  = DATA_W'(-bin);
      source_exp   = e;
      source_error = err ? 2'b01 : 2'b00;
   endtask

   task automatic run_vec(input vec_t v);
      int bin;
      int last_beat_cyc;
      bit got;
      clear_mon();
      last_beat_cyc = -1;
      for (int k = 0; k < v.n_beats; k++) begin
         bin = (v.sop2_at >= 0 && k >= v.sop2_at) ? k - v.sop2_at : k;
         drive_beat(k, bin, (k == 0) || (k == v.sop2_at), k == v.eop_at, v.exp, k == v.err_at);
         if (k < v.exp_writes) exp_q.push_back('{addr: ADDR_W'(bin), data: exp_data(bin, -bin)});
         else check({v.name, " ready held off"}, 64'(source_ready), 64'd0);
         @(posedge clk); #1;
         if (k < v.exp_writes) last_beat_cyc = cyc;
      end
      idle_inputs();
      if (v.exp_done) begin
         got = 1'b0;
         for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            got = frame_done;
         end
         check({v.name, " done seen"}, 64'(got), 64'd1);
         if (got) begin
            check({v.name, " ready in hold"}, 64'(source_ready), 64'd0);
            rd_release = 1'b1;
            @(posedge clk); #1;
            rd_release = 1'b0;
            check({v.name, " ready after release"}, 64'(source_ready), 64'd1);
         end
      end
      repeat (4) @(negedge clk);
      @(posedge clk); #1;
      check({v.name, " write count"}, 64'(wr_cnt), 64'(v.exp_writes));
      check({v.name, " write mismatches"}, 64'(bad_wr), 64'd0);
      check({v.name, " last addr"}, 64'(last_wr_addr), 64'(v.exp_last_addr));
      check({v.name, " write latency"}, 64'(last_wr_cyc), 64'(last_beat_cyc + LAT - 1));
      check({v.name, " done count"}, 64'(done_cnt), 64'(v.exp_done));
      check({v.name, " drop count"}, 64'(drop_cnt), 64'(v.exp_drop));
      if (v.exp_done) begin
         check({v.name, " done timing"}, 64'(done_cyc), 64'(last_wr_cyc + 1));
         check({v.name, " frame_err"}, 64'(done_err), 64'(v.exp_err));
         check({v.name, " exp at done"}, 64'(done_exp), 64'(v.exp));
         prev_exp = v.exp;
      end
      if (v.exp_drop) check({v.name, " drop timing"}, 64'(drop_cyc), 64'(last_wr_cyc + 1));
      check({v.name, " frame_exp held"}, 64'(frame_exp), 64'(prev_exp));
      check({v.name, " ready idle"}, 64'(source_ready), 64'd1);
   endtask

   initial begin
      //          name          beats eop  sop2 err exp   writes last done drop err
      vecs[0] = '{"clean",       512, 511,  -1, -1, 6'd5,  512, 511, 1'b1, 1'b0, 3'b000};
      vecs[1] = '{"short",       100,  99,  -1, -1, 6'd7,  100,  99, 1'b0, 1'b1, 3'b000};
      vecs[2] = '{"after_short", 512, 511,  -1, -1, 6'd9,  512, 511, 1'b1, 1'b0, 3'b000};
      vecs[3] = '{"restart",     812, 811, 300, -1, 6'd12, 812, 511, 1'b1, 1'b0, 3'b010};
      vecs[4] = '{"core_err",    512, 511,  -1,  7, 6'd3,  512, 511, 1'b1, 1'b0, 3'b001};
      vecs[5] = '{"core_long",   513,  -1,  -1,  7, 6'd33, 512, 511, 1'b1, 1'b0, 3'b101};
      vecs[6] = '{"long",        513,  -1,  -1, -1, 6'd63, 512, 511, 1'b1, 1'b0, 3'b100};

      // Reset state: every output reads 0 while rst is held.
      repeat (3) @(posedge clk);
      #1;
      check("reset outputs zero",
            64'({source_ready, buf_wr_en, buf_wr_addr, buf_wr_data, frame_done, frame_exp, frame_err, frame_drop}),
            64'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("ready after reset", 64'(source_ready), 64'd1);

      for (int i = 0; i < 7; i++) run_vec(vecs[i]);

      // Reset in the middle of a frame, at bin 200.
      clear_mon();
      for (int k = 0; k <= 200; k++) begin
         drive_beat(k, k, k == 0, 1'b0, 6'd21, 1'b0);
         if (k == 200) rst = 1'b1;
         @(posedge clk); #1;
      end
      idle_inputs();
      check("mid-frame reset outputs zero",
            64'({source_ready, buf_wr_en, buf_wr_addr, buf_wr_data, frame_done, frame_exp, frame_err, frame_drop}),
            64'd0);
      @(posedge clk); #1;
      check("ready low in reset", 64'(source_ready), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("ready after mid reset", 64'(source_ready), 64'd1);
      repeat (4) @(posedge clk);
      #1;
      check("no done after reset", 64'(done_cnt), 64'd0);
      check("no drop after reset", 64'(drop_cnt), 64'd0);
      prev_exp = '0;
      run_vec(vecs[0]);

      // Single sop beat real=3, imag=-4: data and write latency.
      clear_mon();
      exp_q.push_back('{addr: '0, data: exp_data(3, -4)});
      source_valid = 1'b1; source_sop = 1'b1;
      source_real = DATA_W'(3); source_imag = DATA_W'(-4); source_exp = 6'd1;
      @(posedge clk); #1;
      idle_inputs();
`ifdef FFT_RX_MAG_EN
      check("mag no early write", 64'(buf_wr_en), 64'd0);
      @(posedge clk); #1;
`endif
      check("single beat wr_en", 64'(buf_wr_en), 64'd1);
      check("single beat addr", 64'(buf_wr_addr), 64'd0);
      check("single beat data", 64'(buf_wr_data), 64'(exp_data(3, -4)));
      @(posedge clk); #1;
      check("single beat strobe ends", 64'(buf_wr_en), 64'd0);

      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fft_frame_rx.md
# fft_frame_rx

Receive side of the FFT streaming interface. Accepts the Avalon-ST source stream of the FFT core (one 512-bin frame per transform, started by the sink-side frame generator), checks sop/eop framing against the bin count, and writes each bin into an external frame buffer addressed by bin index. It then holds off the core with `source_ready` until the downstream consumer releases the buffer.

## Interface
- `FFT_LEN`, 512: bins per frame; a power of two.
- `DATA_W`, 16: width of the real and imaginary parts.
- `EXP_W`, 6: width of the block exponent.
- `clk` in 1: single clock.
- `rst` in 1: reset; synchronous, active-high.
- `source_valid` in 1: core output beat valid.
- `source_sop` in 1: first bin of the frame.
- `source_eop` in 1: last bin of the frame.
- `source_real` in DATA_W: real part, signed.
- `source_imag` in DATA_W: imaginary part, signed.
- `source_exp` in EXP_W: block exponent; sampled on the sop beat.
- `source_error` in 2: core error code; any nonzero value is an error.
- `source_ready` out 1: backpressure to the core.
- `buf_wr_en` out 1: frame buffer write strobe.
- `buf_wr_addr` out log2(FFT_LEN): bin index.
- `buf_wr_data` out 2*DATA_W, or 2*DATA_W+1 with the magnitude option: {real, imag}, or magnitude squared.
- `frame_done` out 1: one-cycle pulse; a complete frame is in the buffer.
- `frame_exp` out EXP_W: exponent of the last accepted frame.
- `frame_err` out 3: error flags, valid with `frame_done`.
  - bit0 CORE
  - bit1 RESTART
  - bit2 LONG
- `frame_drop` out 1: one-cycle pulse; a short frame was discarded.
- `rd_release` in 1: consumer has finished reading; frees the buffer.

## Operation
- Beat = `source_valid & source_ready`. Nothing outside a beat has any effect.
- IDLE: `source_ready`=1.
  - sop beat: write bin 0, latch `source_exp`, clear the error flags, set the counter to 1, go to CAPTURE.
  - Non-sop beat: discarded silently.
- CAPTURE: `source_ready`=1. Each beat writes bin = counter, then the counter increments.
  - sop beat mid-frame: set RESTART, treat the beat as bin 0 of a new frame, counter = 1, relatch the exponent. CORE is cleared; RESTART stays set.
  - eop beat with counter < FFT_LEN-1: write the beat, pulse `frame_drop`, go to IDLE, no `frame_done`.
  - Beat at counter = FFT_LEN-1:
    - Write it.
    - Set LONG if eop=0.
    - Go to HOLD.
    - Pulse `frame_done`.
    - Later beats of an overlong frame are blocked by `source_ready`=0.
  - A beat with `source_error`≠0 sets CORE; the flag is sticky for the frame.
- HOLD: `source_ready`=0. `rd_release`=1 leads to IDLE next cycle. `rd_release` outside HOLD is ignored.
- The counter is log2(FFT_LEN) bits and wraps only via the state transitions, never by overflow.
- Reset at any point:
  - Aborts the frame and returns to IDLE.
  - No `frame_done` or `frame_drop`.
  - Buffer contents are undefined.

## Timing
- While `rst`=1, all outputs are 0: `source_ready`, `buf_wr_*`, `frame_done`, `frame_exp`, `frame_err`, `frame_drop`.
- `source_ready`=1 from the first cycle after `rst` falls.
- `source_ready` is a registered state decode. It drops the cycle after the last-bin beat.
- Write latency: `buf_wr_*` registered, 1 cycle after the beat; 2 cycles with the magnitude option.
- `frame_done` and `frame_err` are asserted the cycle after the last `buf_wr_en`.
- `frame_exp` is updated when `frame_done` is asserted and held until the next `frame_done`.
- `frame_drop` is asserted the cycle after the write of the short-frame eop beat.
- Minimum frame-to-frame gap at the core: 2 cycles, achieved with `rd_release` asserted in the same cycle as `frame_done`.

## Configuration
- `FFT_RX_MAG_EN` defined:
  - `buf_wr_data` = real² + imag², unsigned, 2*DATA_W+1 bits.
  - One extra pipeline stage on `buf_wr_*`. `frame_done` stays aligned one cycle after the last write.
- Not defined:
  - `buf_wr_data` = {real, imag}, 2*DATA_W bits.
  - Write latency 1.

## Structure
- Package `fft_rx_pkg`:
  - State enum (IDLE, CAPTURE, HOLD).
  - Bit indices ERR_CORE=0, ERR_RESTART=1, ERR_LONG=2.
  - Default FFT_LEN/DATA_W/EXP_W constants.
- Sub-module `fft_mag_sq`: one-stage registered magnitude-squared unit. Instantiated only under `FFT_RX_MAG_EN`.

## Test plan
- 512 clean beats:
  - Bin n carries real=n, imag=-n; sop on bin 0, eop on bin 511, exp=5.
  - Expect 512 writes, addr 0..511, data {n,-n}.
  - `frame_done` 1 cycle after the addr-511 write, `frame_err`=0, `frame_exp`=5, `source_ready`=0 until `rd_release`.
- Eop on bin 99 → 100 writes, `frame_drop` pulse, no `frame_done`; the next sop frame completes normally.
- Sop re-asserted at bin 300, followed by 512 clean beats → `frame_done` with `frame_err`=3'b010, last write addr 511.
- `source_error`=2'b01 on bin 7 only → `frame_err`=3'b001; no eop on bin 511 → `frame_err`=3'b101. Beat 513 is held off (`source_ready`=0).
- `rst` pulsed at bin 200 → outputs 0 during reset. The following clean frame gives `frame_done` with `frame_err`=0.
- With `FFT_RX_MAG_EN`: real=3, imag=-4 → `buf_wr_data`=25, 2 cycles after the beat.
